// File: rtl/data_sram_resp.sv
// Data SRAM responder: word RAM plus MMIO window (LED, NUM, SWITCH, TIMER), one-cycle read-first latency.
// Optional timer compare interrupt enabled by DATA_SRAM_RESP_TIMER_IRQ_EN.
module data_sram_resp #(
    parameter int          ADDR_W  = 14,
    parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out,
    output logic        timer_irq
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [15:0] OFF_LED   = 16'h0000;
    localparam logic [15:0] OFF_NUM   = 16'h0004;
    localparam logic [15:0] OFF_SW    = 16'h0008;
    localparam logic [15:0] OFF_TIMER = 16'h000C;
    localparam logic [15:0] OFF_CMP   = 16'h0010;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    logic [31:0] mem [DEPTH];
    logic [31:0] ram_rd_q;

    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic        rsel_q, rsel_d;
    logic [31:0] mmio_rd_q, mmio_rd_d;

    logic              mmio_sel;
    logic [15:0]       off;
    logic [ADDR_W-1:0] word_idx;
    logic              ram_acc;
    logic              mmio_wr;
    logic [31:0]       mmio_val;
    logic [31:0]       wmerged;

    assign mmio_sel = (data_sram_addr[31:16] == MMIO_HI);
    assign off      = data_sram_addr[15:0];
    assign word_idx = data_sram_addr[ADDR_W+1:2];
    assign ram_acc  = data_sram_en && !rst && !mmio_sel;
    assign mmio_wr  = data_sram_en && mmio_sel && (data_sram_wen != 4'b0);

`ifdef DATA_SRAM_RESP_TIMER_IRQ_EN
    logic [31:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;
`endif

    // RAM kept as a plain read-first synchronous port so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_acc) begin
            ram_rd_q <= mem[word_idx];
            for (int b = 0; b < 4; b++)
                if (data_sram_wen[b]) mem[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
    end

    always_comb begin
        mmio_val = 32'h0;
        case (off)
            OFF_LED:   mmio_val = {16'h0, led_q};
            OFF_NUM:   mmio_val = num_q;
            OFF_SW:    mmio_val = {24'h0, sw_sync_q};
            OFF_TIMER: mmio_val = timer_q;
`ifdef DATA_SRAM_RESP_TIMER_IRQ_EN
            OFF_CMP:   mmio_val = cmp_q;
`endif
            default:   mmio_val = 32'h0;
        endcase
    end

    always_comb begin
        wmerged   = 32'h0;
        led_d     = led_q;
        num_d     = num_q;
        timer_d   = timer_q + 32'd1;
        rsel_d    = rsel_q;
        mmio_rd_d = mmio_rd_q;
        if (data_sram_en) begin
            rsel_d    = mmio_sel;
            mmio_rd_d = mmio_val;
        end
        if (mmio_wr) begin
            case (off)
                OFF_LED:   begin wmerged = merge({16'h0, led_q}, data_sram_wdata, data_sram_wen);
                                 led_d = wmerged[15:0]; end
                OFF_NUM:   num_d   = merge(num_q, data_sram_wdata, data_sram_wen);
                OFF_TIMER: timer_d = merge(timer_q, data_sram_wdata, data_sram_wen);
                default:   ;
            endcase
        end
    end

`ifdef DATA_SRAM_RESP_TIMER_IRQ_EN
    // A CMP write in the same cycle as a match clears, so the clear is applied last.
    always_comb begin
        cmp_d = cmp_q;
        irq_d = irq_q;
        if (timer_q == cmp_q) irq_d = 1'b1;
        if (mmio_wr && off == OFF_CMP) begin
            cmp_d = merge(cmp_q, data_sram_wdata, data_sram_wen);
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q <= 32'hFFFF_FFFF;
            irq_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign timer_irq = irq_q;
`else
    assign timer_irq = 1'b0;
`endif

    // Reset parks the output mux on the MMIO side holding zero, so rdata reads 0 without resetting the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q     <= 16'h0;
            num_q     <= 32'h0;
            timer_q   <= 32'h0;
            sw_meta_q <= 8'h0;
            sw_sync_q <= 8'h0;
            rsel_q    <= 1'b1;
            mmio_rd_q <= 32'h0;
        end else begin
            led_q     <= led_d;
            num_q     <= num_d;
            timer_q   <= timer_d;
            sw_meta_q <= switch_in;
            sw_sync_q <= sw_meta_q;
            rsel_q    <= rsel_d;
            mmio_rd_q <= mmio_rd_d;
        end
    end

    assign data_sram_rdata = rsel_q ? mmio_rd_q : ram_rd_q;
    assign led_out         = led_q;
    assign num_out         = num_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: directed literal checks plus randomized traffic against a behavioural model.
module tb_data_sram_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [7:0]  switch_in = 8'h0;
    logic [15:0] led_out;
    logic [31:0] num_out;
    logic        timer_irq;

    int n_chk = 0;
    int n_fail = 0;

    data_sram_resp dut (
        .clk(clk), .rst(rst),
        .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
        .data_sram_wdata(wdata), .data_sram_rdata(rdata),
        .switch_in(switch_in), .led_out(led_out), .num_out(num_out),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [int];
    logic [31:0] m_rdata;
    logic [15:0] m_led;
    logic [31:0] m_num, m_timer, m_cmp;
    logic        m_irq;
    logic [7:0]  m_sw [2];
    bit          m_ok = 0;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_rdata = 32'h0; m_led = 16'h0; m_num = 32'h0; m_timer = 32'h0;
            m_cmp = 32'hFFFF_FFFF; m_irq = 1'b0; m_sw[0] = 8'h0; m_sw[1] = 8'h0;
            m_ok = 1;
        end else if (m_ok) begin
            logic [31:0] next_timer;
            logic        is_mmio, cmp_wr;
            int          widx;
            logic [15:0] o;
            is_mmio = (addr[31:16] == 16'hBFAF);
            o = addr[15:0];
            widx = int'(addr[15:2]);
            next_timer = m_timer + 1;
            cmp_wr = 0;
            if (en) begin
                if (is_mmio) begin
                    if (o == 16'h0) m_rdata = {16'h0, m_led};
                    else if (o == 16'h4) m_rdata = m_num;
                    else if (o == 16'h8) m_rdata = {24'h0, m_sw[1]};
                    else if (o == 16'hC) m_rdata = m_timer;
`ifdef DATA_SRAM_RESP_TIMER_IRQ_EN
                    else if (o == 16'h10) m_rdata = m_cmp;
`endif
                    else m_rdata = 32'h0;
                    if (wen != 0) begin
                        if (o == 16'h0) m_led = bmerge({16'h0, m_led}, wdata, wen) & 32'hFFFF;
                        else if (o == 16'h4) m_num = bmerge(m_num, wdata, wen);
                        else if (o == 16'hC) next_timer = bmerge(m_timer, wdata, wen);
                        else if (o == 16'h10) cmp_wr = 1;
                    end
                end else begin
                    m_rdata = m_ram.exists(widx) ? m_ram[widx] : 32'hx;
                    if (wen != 0)
                        m_ram[widx] = bmerge(m_ram.exists(widx) ? m_ram[widx] : 32'hx, wdata, wen);
                end
            end
`ifdef DATA_SRAM_RESP_TIMER_IRQ_EN
            if (m_timer == m_cmp) m_irq = 1'b1;
            if (cmp_wr) begin m_cmp = bmerge(m_cmp, wdata, wen); m_irq = 1'b0; end
`endif
            m_timer = next_timer;
            m_sw[1] = m_sw[0];
            m_sw[0] = switch_in;
        end
    end

    // One compare process, mid-cycle, against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            if (!$isunknown(m_rdata)) chk("model_rdata", rdata, m_rdata);
            chk("model_led", {16'h0, led_out}, {16'h0, m_led});
            chk("model_num", num_out, m_num);
            chk("model_irq", {31'h0, timer_irq}, {31'h0, m_irq});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; wen = w; addr = a; wdata = d;
        @(posedge clk); #1;
    endtask

    localparam logic [31:0] MM = 32'hBFAF_0000;

    initial begin
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst = 1'b0;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_led", {16'h0, led_out}, 32'h0);
        chk("reset_num", num_out, 32'h0);
        chk("reset_irq", {31'h0, timer_irq}, 32'h0);

        cyc(1, 4'hF, 32'h10, 32'h1234_5678);
        cyc(1, 4'h0, 32'h10, 32'h0);
        chk("ram_full_write", rdata, 32'h1234_5678);

        cyc(1, 4'hF, 32'h20, 32'h1122_3344);
        cyc(1, 4'b0101, 32'h20, 32'hAABB_CCDD);
        chk("write_returns_old", rdata, 32'h1122_3344);
        cyc(1, 4'h0, 32'h20, 32'h0);
        chk("byte_merge", rdata, 32'h11BB_33DD);
        cyc(0, 4'h0, 32'h0, 32'h0);
        chk("rdata_hold", rdata, 32'h11BB_33DD);

        cyc(1, 4'hF, MM | 32'h0, 32'h0000_A5A5);
        chk("led_write", {16'h0, led_out}, 32'h0000_A5A5);
        cyc(1, 4'h0, MM | 32'h40, 32'h0);
        chk("unmapped_read", rdata, 32'h0);
        cyc(1, 4'hF, MM | 32'h8, 32'hFFFF_FFFF);
        cyc(1, 4'hF, MM | 32'h4, 32'hCAFE_F00D);
        chk("num_write", num_out, 32'hCAFE_F00D);

        switch_in = 8'h3C;
        cyc(1, 4'h0, MM | 32'h8, 32'h0);
        chk("switch_same_cycle_old", rdata, 32'h0);
        cyc(0, 4'h0, 32'h0, 32'h0);
        cyc(1, 4'h0, MM | 32'h8, 32'h0);
        chk("switch_after_sync", rdata, 32'h0000_003C);

        cyc(1, 4'hF, MM | 32'hC, 32'hFFFF_FFFE);
        cyc(0, 4'h0, 32'h0, 32'h0);
        cyc(1, 4'h0, MM | 32'hC, 32'h0);
        chk("timer_ffff", rdata, 32'hFFFF_FFFF);
        cyc(1, 4'h0, MM | 32'hC, 32'h0);
        chk("timer_wrap", rdata, 32'h0);

        rst = 1'b1;
        cyc(1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        rst = 1'b0;
        chk("rst_mid_rdata", rdata, 32'h0);
        chk("rst_mid_led", {16'h0, led_out}, 32'h0);
        cyc(1, 4'h0, MM | 32'hC, 32'h0);
        chk("rst_mid_timer", rdata, 32'h0);
        cyc(1, 4'h0, 32'h10, 32'h0);
        chk("dropped_write", rdata, 32'h1234_5678);

`ifdef DATA_SRAM_RESP_TIMER_IRQ_EN
        cyc(1, 4'hF, MM | 32'h10, 32'h20);
        cyc(1, 4'hF, MM | 32'hC, 32'h1E);
        chk("irq_low_0", {31'h0, timer_irq}, 32'h0);
        cyc(0, 4'h0, 32'h0, 32'h0);
        cyc(0, 4'h0, 32'h0, 32'h0);
        chk("irq_low_2", {31'h0, timer_irq}, 32'h0);
        cyc(0, 4'h0, 32'h0, 32'h0);
        chk("irq_rise_3", {31'h0, timer_irq}, 32'h1);
        cyc(0, 4'h0, 32'h0, 32'h0);
        cyc(0, 4'h0, 32'h0, 32'h0);
        chk("irq_sticky", {31'h0, timer_irq}, 32'h1);
        cyc(1, 4'hF, MM | 32'h10, 32'hFFFF_FFFF);
        chk("irq_clear", {31'h0, timer_irq}, 32'h0);
`else
        cyc(1, 4'hF, MM | 32'h10, 32'h20);
        cyc(1, 4'h0, MM | 32'h10, 32'h0);
        chk("cmp_unmapped", rdata, 32'h0);
        chk("irq_tied_low", {31'h0, timer_irq}, 32'h0);
`endif

        // Randomized traffic over a small RAM region (with aliased upper bits) and the MMIO window.
        for (int i = 0; i < 16; i++)
            cyc(1, 4'hF, {16'h0, 14'(64 + i), 2'b00}, $urandom);
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            logic [15:0] hi;
            logic [3:0]  w;
            int          k;
            hi = 16'($urandom);
            if (hi == 16'hBFAF) hi = 16'h0;
            a = {hi, 14'(64 + $urandom_range(0, 15)), 2'($urandom)};
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 6);
                a = MM | ((k == 6) ? 32'h40 : 32'(k * 4));
            end
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 15) == 0) switch_in = 8'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            cyc($urandom_range(0, 3) != 0, w, a, $urandom);
        end
        rst = 1'b0;
        cyc(0, 4'h0, 32'h0, 32'h0);
        cyc(0, 4'h0, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
